// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PCSrc encodings from Control and the fixed
// kernel-space vectors used by the fetch stage, Control and the link mux.
package cpu_pkg;

  typedef enum logic [2:0] {
    PCSRC_SEQ   = 3'd0,
    PCSRC_BR    = 3'd1,
    PCSRC_J     = 3'd2,
    PCSRC_JR    = 3'd3,
    PCSRC_IRQ   = 3'd4,
    PCSRC_UNDEF = 3'd5
  } pcsrc_e;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
  localparam logic [31:0] XADR_VEC  = 32'h8000_0008;

  // Advance a PC by one word without ever touching the supervisor bit.
  function automatic logic [31:0] pc_inc4(input logic [31:0] pc_val);
    return {pc_val[31], pc_val[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/irq_latch.sv
// Edge-latched interrupt request for the fetch stage.
// Optional macro IRQ_SYNC_EN inserts a 2-flop synchronizer on irq_in.
module irq_latch
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic clear,
  output logic pending
);

  logic irq_s;
  logic irq_prev_q, irq_prev_d;
  logic pending_q, pending_d;

`ifdef IRQ_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Synchronizer chain: the edge detector only ever sees the second stage.
  always_comb begin
    sync1_d = irq_in;
    sync2_d = sync1_q;
  end

  // Synchronizer flops clear on reset so no phantom edge appears afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  // A new rising edge beats a same-cycle clear so no request is ever lost.
  always_comb begin
    irq_prev_d = irq_s;
    pending_d  = pending_q;
    if (irq_s && !irq_prev_q) begin
      pending_d = 1'b1;
    end else if (clear) begin
      pending_d = 1'b0;
    end
  end

  // irq_prev follows the line every cycle, stalls included.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_prev_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter stage in front of the single-cycle Control block.
// PC[31] is the supervisor bit; low 31 bits wrap on all arithmetic.
// Optional macro IRQ_SYNC_EN (inside irq_latch) adds an irq_in synchronizer.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VEC = cpu_pkg::RESET_VEC,
  parameter logic [31:0] ILLOP_VEC = cpu_pkg::ILLOP_VEC,
  parameter logic [31:0] XADR_VEC  = cpu_pkg::XADR_VEC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [2:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] instruct,
  input  logic [31:0] rs_data,
  input  logic        irq_in,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] link_addr,
  output logic        irq_req,
  output logic        kernel
);

  import cpu_pkg::*;

  logic [31:0] pc_q, pc_d;
  logic [31:0] br_off;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] jr_target;
  logic        irq_clear;
  logic        irq_pending;
  logic        instr_unused;

  assign pc       = pc_q;
  assign kernel   = pc_q[31];
  assign pc_plus4 = pc_inc4(pc_q);

  // Target candidates; bit 31 is carried from the current PC except for jr.
  assign br_off    = {{14{instruct[15]}}, instruct[15:0], 2'b00};
  assign br_target = {pc_q[31], pc_plus4[30:0] + br_off[30:0]};
  assign j_target  = {pc_q[31], pc_plus4[30:28], instruct[25:0], 2'b00};
  assign jr_target = kernel ? rs_data : {1'b0, rs_data[30:0]};
  assign instr_unused = ^instruct[31:26];

  // Next-PC select; a stall freezes the PC regardless of pc_src.
  always_comb begin
    pc_d = pc_q;
    if (!stall) begin
      case (pc_src)
        PCSRC_SEQ:   pc_d = pc_plus4;
        PCSRC_BR:    pc_d = branch_taken ? br_target : pc_plus4;
        PCSRC_J:     pc_d = j_target;
        PCSRC_JR:    pc_d = jr_target;
        PCSRC_IRQ:   pc_d = ILLOP_VEC;
        PCSRC_UNDEF: pc_d = XADR_VEC;
        default:     pc_d = pc_plus4;
      endcase
    end
  end

  // PC register; reset dominates stall and every select.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VEC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Taking the interrupt vector retires the pending request.
  assign irq_clear = (pc_src == PCSRC_IRQ) && !stall;

  irq_latch u_irq_latch (
    .clk     (clk),
    .reset   (reset),
    .irq_in  (irq_in),
    .clear   (irq_clear),
    .pending (irq_pending)
  );

  // Kernel code is never interrupted; the request waits for user mode.
  assign irq_req = irq_pending & ~kernel;

  // IRQ links to the interrupted instruction so it is re-executed.
  assign link_addr = (pc_src == PCSRC_IRQ) ? pc_q : pc_plus4;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: the driver pushes the expected
// per-cycle outputs from a reference model, a monitor pops and compares.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [2:0]  pc_src;
  logic        branch_taken;
  logic [31:0] instruct;
  logic [31:0] rs_data;
  logic        irq_in;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] link_addr;
  logic        irq_req;
  logic        kernel;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] p4;
    logic [31:0] link;
    logic        req;
    logic        kern;
  } exp_t;

  exp_t expQ[$];

  logic [31:0] mPc;
  logic        mPend;
  logic        mPrev;
  logic        mS1;
  logic        mS2;
  bit          modelKnown = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  pc_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .pc_src       (pc_src),
    .branch_taken (branch_taken),
    .instruct     (instruct),
    .rs_data      (rs_data),
    .irq_in       (irq_in),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .link_addr    (link_addr),
    .irq_req      (irq_req),
    .kernel       (kernel)
  );

  // Sequential address: low 31 bits advance by 4 modulo 2^31, bit 31 kept.
  function automatic logic [31:0] refSeq(input logic [31:0] p);
    longint lo;
    lo = (longint'(p[30:0]) + 64'sd4) % (64'sd1 <<< 31);
    return {p[31], lo[30:0]};
  endfunction

  // Next PC worked out from the architectural rules with plain arithmetic.
  function automatic logic [31:0] refNext(input logic [31:0] p, input logic [2:0] src,
                                          input logic bt, input logic [31:0] ins,
                                          input logic [31:0] rs);
    longint      lo;
    logic [31:0] p4;
    p4 = refSeq(p);
    case (src)
      3'd1: begin
        if (!bt) return p4;
        lo = longint'(p[30:0]) + 64'sd4 + longint'($signed(ins[15:0])) * 64'sd4;
        lo = lo & 64'sh7FFF_FFFF;
        return {p[31], lo[30:0]};
      end
      3'd2:    return (p & 32'h8000_0000) | (p4 & 32'h7000_0000) | {4'b0, ins[25:0], 2'b00};
      3'd3:    return p[31] ? rs : (rs & 32'h7FFF_FFFF);
      3'd4:    return 32'h8000_0004;
      3'd5:    return 32'h8000_0008;
      default: return p4;
    endcase
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("pc", pc, e.pc);
    cmp("pc_plus4", pc_plus4, e.p4);
    cmp("link_addr", link_addr, e.link);
    cmp("irq_req", {31'b0, irq_req}, {31'b0, e.req});
    cmp("kernel", {31'b0, kernel}, {31'b0, e.kern});
  endtask

  // Drive one cycle of inputs, record the expected outputs, advance the model.
  task automatic applyStimulus(input logic r, input logic s, input logic [2:0] src,
                               input logic bt, input logic [31:0] ins,
                               input logic [31:0] rs, input logic irq);
    exp_t e;
    logic irqEff;
    logic rise;
    logic clr;
    reset = r; stall = s; pc_src = src; branch_taken = bt;
    instruct = ins; rs_data = rs; irq_in = irq;
    if (modelKnown) begin
      e.pc   = mPc;
      e.kern = mPc[31];
      e.p4   = refSeq(mPc);
      e.link = (src == 3'd4) ? mPc : e.p4;
      e.req  = mPend && !mPc[31];
      expQ.push_back(e);
    end
    if (r) begin
      mPc = 32'h8000_0000; mPend = 1'b0; mPrev = 1'b0; mS1 = 1'b0; mS2 = 1'b0;
      modelKnown = 1;
    end else if (modelKnown) begin
`ifdef IRQ_SYNC_EN
      irqEff = mS2; mS2 = mS1; mS1 = irq;
`else
      irqEff = irq;
`endif
      rise  = irqEff && !mPrev;
      mPrev = irqEff;
      clr   = (src == 3'd4) && !s;
      if (rise) mPend = 1'b1;
      else if (clr) mPend = 1'b0;
      if (!s) mPc = refNext(mPc, src, bt, ins, rs);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: mid-cycle, compare whatever the driver expected for this cycle.
  always @(negedge clk) begin
    if (expQ.size() != 0) checkOutput(expQ.pop_front());
  end

  initial begin
    logic        rr, ss, bt, irq;
    logic [2:0]  src;
    logic [31:0] ins, rs;
    irq = 1'b0;

    // Reset then straight-line fetch from the reset vector.
    applyStimulus(1, 0, 3'd0, 0, 0, 0, 0);
    applyStimulus(1, 0, 3'd0, 0, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);

    // Branch back/forward from 0x00400010 with imm16 = -2.
    applyStimulus(0, 0, 3'd3, 0, 0, 32'h0040_0010, 0);
    applyStimulus(0, 0, 3'd1, 1, 32'h0000_FFFE, 0, 0);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);
    applyStimulus(0, 0, 3'd1, 0, 32'h0000_FFFE, 0, 0);
    applyStimulus(0, 0, 3'd2, 0, 32'h0BAD_CAFE, 0, 0);

    // jr from user cannot enter kernel; jr from kernel can.
    applyStimulus(0, 0, 3'd3, 0, 0, 32'h0040_0000, 0);
    applyStimulus(0, 0, 3'd3, 0, 0, 32'h8000_0100, 0);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);
    applyStimulus(1, 0, 3'd0, 0, 0, 0, 0);
    applyStimulus(0, 0, 3'd3, 0, 0, 32'h8000_0020, 0);
    applyStimulus(0, 0, 3'd3, 0, 0, 32'h8000_0100, 0);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);

    // User-mode interrupt and its service.
    applyStimulus(0, 0, 3'd3, 0, 0, 32'h0040_0020, 0);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 1);
    applyStimulus(0, 0, 3'd4, 0, 0, 0, 1);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);

    // Interrupt in kernel mode waits for the return to user code.
    applyStimulus(0, 0, 3'd3, 0, 0, 32'h8000_0040, 0);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 1);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 1);
    applyStimulus(0, 0, 3'd3, 0, 0, 32'h0040_0000, 0);
    applyStimulus(0, 0, 3'd4, 0, 0, 0, 0);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);

    // Undefined instruction, then stall holding a pending IRQ, then reset.
    applyStimulus(0, 0, 3'd3, 0, 0, 32'h0040_0008, 0);
    applyStimulus(0, 0, 3'd5, 0, 0, 0, 0);
    applyStimulus(0, 0, 3'd3, 0, 0, 32'h0040_0030, 0);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 1);
    applyStimulus(0, 1, 3'd4, 0, 0, 0, 1);
    applyStimulus(0, 1, 3'd4, 0, 0, 0, 0);
    applyStimulus(0, 1, 3'd4, 0, 0, 0, 0);
    applyStimulus(1, 1, 3'd4, 0, 0, 0, 0);
    applyStimulus(0, 0, 3'd0, 0, 0, 0, 0);

    // Randomized traffic across all selects, stalls, resets and IRQ edges.
    for (int i = 0; i < 400; i++) begin
      rr  = ($urandom_range(0, 99) < 2);
      ss  = ($urandom_range(0, 99) < 12);
      src = 3'($urandom_range(0, 7));
      bt  = 1'($urandom_range(0, 1));
      ins = $urandom;
      rs  = $urandom;
      if ($urandom_range(0, 99) < 20) irq = ~irq;
      applyStimulus(rr, ss, src, bt, ins, rs, irq);
    end

    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain got=%0d want=0 entries left", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage directly upstream of the single-cycle Control block.
- Holds the PC and the supervisor (kernel) bit, which is PC[31].
- Latches external interrupt requests and presents a registered IRQ request to Control.
- Computes the next PC from Control's 3-bit PCSrc, and produces the link value that Control routes to the register file.

Parameters:
- RESET_VEC, 32'h8000_0000, PC value after reset (kernel mode).
- ILLOP_VEC, 32'h8000_0004, interrupt handler entry (PCSrc=4).
- XADR_VEC, 32'h8000_0008, undefined-instruction handler entry (PCSrc=5).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and pending-IRQ clear for this cycle.
- pc_src  in  3  next-PC select from Control: 0 seq, 1 branch, 2 j/jal, 3 jr/jalr, 4 IRQ, 5 undefined.
- branch_taken  in  1  ALU result bit 0 for the current branch.
- instruct  in  32  current instruction; uses imm16 [15:0] and target [25:0].
- rs_data  in  32  register-file rs read value, used by jr/jalr.
- irq_in  in  1  level interrupt line from the timer peripheral.
- pc  out  32  current fetch address.
- pc_plus4  out  32  {pc[31], pc[30:0]+4}.
- link_addr  out  32  value written by jal/jalr/IRQ/undefined.
- irq_req  out  1  registered request, drives Control's IRQ input.
- kernel  out  1  equals pc[31].

Behaviour:
- Reset (synchronous, active-high, dominates all other inputs):
  - pc=RESET_VEC.
  - irq_pending=0 and irq_prev=0.
  - Outputs after reset: irq_req=0, kernel=1, pc_plus4=RESET_VEC+4, link_addr=RESET_VEC+4.
- Next-PC selection, registered on each rising edge when reset=0 and stall=0:
  - 0: pc_plus4.
  - 1: branch_taken ? branch target : pc_plus4.
    - Branch target = {pc[31], pc_plus4[30:0] + (sext(imm16)<<2)[30:0]}.
  - 2: {pc[31], pc_plus4[30:28], target, 2'b00}.
  - 3: kernel ? rs_data : {1'b0, rs_data[30:0]}. User code cannot enter kernel via jr.
  - 4: ILLOP_VEC.
  - 5: XADR_VEC.
  - 6, 7: pc_plus4.
- Arithmetic wraps modulo 2^31 on bits [30:0]. Bit 31 changes only via reset, vectors 4/5, or jr from kernel.
- stall=1: pc holds; pc_src is ignored.
- irq_pending (edge-latched):
  - Sets on a rising edge of irq_in, i.e. irq_in=1 and irq_prev=0.
  - Clears when pc_src==4 and stall=0.
  - A new edge in the same cycle as a clear: set wins.
  - irq_prev tracks irq_in every cycle, including during stall.
- irq_req = irq_pending & ~kernel.
  - Combinational from registers only, so there is no loop through Control.
  - An IRQ arriving in kernel mode stays pending and asserts on the first user-mode cycle.
- link_addr = (pc_src==4) ? pc : pc_plus4.
  - On IRQ the interrupted instruction is re-executed after return.
  - On undefined instructions and jal the link is the next instruction.
- IRQ latency: irq_in rising edge at cycle N gives irq_req=1 in cycle N+1 (user mode) and pc=ILLOP_VEC in cycle N+2.

Optional Feature:
- Macro IRQ_SYNC_EN.
- When defined: irq_in passes through a 2-flop synchronizer before edge detection.
  - Adds 2 cycles of latency: irq_req asserts in cycle N+3.
  - Synchronizer flops reset to 0.
- When undefined: irq_in is used directly, with timing as in Behaviour.

Decomposition:
- Shared package (cpu_pkg):
  - PCSrc encodings PCSRC_SEQ, PCSRC_BR, PCSRC_J, PCSRC_JR, PCSRC_IRQ, PCSRC_UNDEF.
  - Vector constants RESET_VEC, ILLOP_VEC, XADR_VEC, shared with Control and the register-file link mux.
- One sub-module, irq_latch:
  - Contains the optional synchronizer, irq_prev, irq_pending and the set/clear priority.
  - Inputs: clk, reset, irq_in, clear. Output: pending.

Test Plan:
- Reset, then 3 cycles with pc_src=0 -> pc = 0x80000000, 0x80000004, 0x80000008, 0x8000000C; kernel=1.
- pc=0x00400010, pc_src=1, imm16=16'hFFFE:
  - branch_taken=1 -> pc=0x0040000C.
  - branch_taken=0 -> pc=0x00400014.
- pc=0x00400000 (user), pc_src=3, rs_data=0x80000100 -> pc=0x00000100, kernel=0.
  - Same stimulus from pc=0x80000020 -> pc=0x80000100.
- irq_in rises at pc=0x00400020 (user) -> irq_req=1 next cycle.
  - Drive pc_src=4 -> link_addr=current pc, next pc=0x80000004, irq_req=0 afterward.
- irq_in rises while pc=0x80000040 (kernel) -> irq_req stays 0; after jr to 0x00400000, irq_req=1 on the first user cycle.
- pc_src=5 at pc=0x00400008 -> link_addr=0x0040000C, next pc=0x80000008.
  - stall=1 with pc_src=4 pending -> pc holds and pending is not cleared.
  - Reset asserted mid-stall -> pc=0x80000000.
